// File: rtl/i2c_mmio_arbiter.sv
// Two-requester arbiter for a shared I2C peripheral MMIO port.
// Ownership is held for whole transactions (request held high), handed over
// through a one-cycle GAP, with round-robin tie breaking and an idle watchdog
// that forcibly revokes a grant left unused for TIMEOUT_CYCLES owned cycles.
//
// state | meaning
// IDLE  | no owner, arbitrate among eligible requests
// OWN0  | requester 0 holds the peripheral
// OWN1  | requester 1 holds the peripheral
// GAP   | one dead cycle after release or revoke, no grants, no strobes
module i2c_mmio_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        r0_req,
    output logic        r0_gnt,
    output logic        r0_timeout,
    input  logic [31:0] r0_data_in,
    input  logic [31:0] r0_config_in,
    input  logic        r0_data_wr,
    input  logic        r0_data_rd,
    input  logic        r0_config_wr,
    output logic [31:0] r0_data_out,
    output logic [31:0] r0_config_out,

    input  logic        r1_req,
    output logic        r1_gnt,
    output logic        r1_timeout,
    input  logic [31:0] r1_data_in,
    input  logic [31:0] r1_config_in,
    input  logic        r1_data_wr,
    input  logic        r1_data_rd,
    input  logic        r1_config_wr,
    output logic [31:0] r1_data_out,
    output logic [31:0] r1_config_out,

    output logic [31:0] data_in,
    output logic [31:0] config_in,
    output logic        data_wr,
    output logic        data_rd,
    output logic        config_wr,
    input  logic [31:0] data_out,
    input  logic [31:0] config_out
);

    // A zero timeout disables the watchdog; keep the counter one bit wide then.
    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t          state;
    logic            last_served;
    logic            block_0;
    logic            block_1;
    logic [CW-1:0]   wd_cnt;

    logic            elig_0;
    logic            elig_1;
    logic            fwd_strobe;
    logic            wd_fire;

    // Strobes reach the peripheral only from the current owner; others are dropped.
    assign data_wr   = (r0_gnt & r0_data_wr)   | (r1_gnt & r1_data_wr);
    assign data_rd   = (r0_gnt & r0_data_rd)   | (r1_gnt & r1_data_rd);
    assign config_wr = (r0_gnt & r0_config_wr) | (r1_gnt & r1_config_wr);

    assign data_in   = r0_gnt ? r0_data_in   : (r1_gnt ? r1_data_in   : 32'd0);
    assign config_in = r0_gnt ? r0_config_in : (r1_gnt ? r1_config_in : 32'd0);

    assign r0_data_out   = r0_gnt ? data_out   : 32'd0;
    assign r0_config_out = r0_gnt ? config_out : 32'd0;
    assign r1_data_out   = r1_gnt ? data_out   : 32'd0;
    assign r1_config_out = r1_gnt ? config_out : 32'd0;

    assign elig_0     = r0_req & ~block_0;
    assign elig_1     = r1_req & ~block_1;
    assign fwd_strobe = data_wr | data_rd | config_wr;

    // Fires on the edge where the idle count would reach the limit; a strobe
    // in that same cycle counts as activity and suppresses the revoke.
    assign wd_fire = (TIMEOUT_CYCLES != 0) && !fwd_strobe &&
                     ((32'(wd_cnt) + 32'd1) == TIMEOUT_CYCLES);

    // Arbitration FSM with registered grants, timeout pulses and watchdog.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            r0_gnt      <= 1'b0;
            r1_gnt      <= 1'b0;
            r0_timeout  <= 1'b0;
            r1_timeout  <= 1'b0;
            block_0     <= 1'b0;
            block_1     <= 1'b0;
            last_served <= 1'b1;
            wd_cnt      <= '0;
        end else begin
            r0_timeout <= 1'b0;
            r1_timeout <= 1'b0;
            // A blocked requester rearms once it has dropped req for a cycle.
            if (!r0_req) block_0 <= 1'b0;
            if (!r1_req) block_1 <= 1'b0;

            case (state)
                IDLE: begin
                    if (elig_0 && (!elig_1 || last_served)) begin
                        state       <= OWN0;
                        r0_gnt      <= 1'b1;
                        last_served <= 1'b0;
                        wd_cnt      <= '0;
                    end else if (elig_1) begin
                        state       <= OWN1;
                        r1_gnt      <= 1'b1;
                        last_served <= 1'b1;
                        wd_cnt      <= '0;
                    end
                end
                OWN0: begin
                    if (!r0_req) begin
                        state  <= GAP;
                        r0_gnt <= 1'b0;
                    end else if (wd_fire) begin
                        state      <= GAP;
                        r0_gnt     <= 1'b0;
                        r0_timeout <= 1'b1;
                        block_0    <= 1'b1;
                    end else if (fwd_strobe) begin
                        wd_cnt <= '0;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        wd_cnt <= wd_cnt + CW'(1);
                    end
                end
                OWN1: begin
                    if (!r1_req) begin
                        state  <= GAP;
                        r1_gnt <= 1'b0;
                    end else if (wd_fire) begin
                        state      <= GAP;
                        r1_gnt     <= 1'b0;
                        r1_timeout <= 1'b1;
                        block_1    <= 1'b1;
                    end else if (fwd_strobe) begin
                        wd_cnt <= '0;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        wd_cnt <= wd_cnt + CW'(1);
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    r0_gnt <= 1'b0;
                    r1_gnt <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_mmio_arbiter.sv
// Bench for i2c_mmio_arbiter: directed vector table, hand-written watchdog and
// reset sequences, then randomized traffic against an ownership-level model.
module tb_i2c_mmio_arbiter;

    localparam int TO = 8;
    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    localparam logic [31:0] D0  = 32'h0000_00A5;
    localparam logic [31:0] D1  = 32'h0000_5A5A;
    localparam logic [31:0] C0  = 32'h0000_0077;
    localparam logic [31:0] C1  = 32'h0000_1234;
    localparam logic [31:0] PDO = 32'hDEAD_0001;
    localparam logic [31:0] PCO = 32'hC0F1_0002;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_req, r0_gnt, r0_timeout;
    logic [31:0] r0_data_in, r0_config_in, r0_data_out, r0_config_out;
    logic        r0_data_wr, r0_data_rd, r0_config_wr;
    logic        r1_req, r1_gnt, r1_timeout;
    logic [31:0] r1_data_in, r1_config_in, r1_data_out, r1_config_out;
    logic        r1_data_wr, r1_data_rd, r1_config_wr;
    logic [31:0] data_in, config_in, data_out, config_out;
    logic        data_wr, data_rd, config_wr;

    int checks = 0;
    int errors = 0;

    i2c_mmio_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_gnt(r0_gnt), .r0_timeout(r0_timeout),
        .r0_data_in(r0_data_in), .r0_config_in(r0_config_in),
        .r0_data_wr(r0_data_wr), .r0_data_rd(r0_data_rd), .r0_config_wr(r0_config_wr),
        .r0_data_out(r0_data_out), .r0_config_out(r0_config_out),
        .r1_req(r1_req), .r1_gnt(r1_gnt), .r1_timeout(r1_timeout),
        .r1_data_in(r1_data_in), .r1_config_in(r1_config_in),
        .r1_data_wr(r1_data_wr), .r1_data_rd(r1_data_rd), .r1_config_wr(r1_config_wr),
        .r1_data_out(r1_data_out), .r1_config_out(r1_config_out),
        .data_in(data_in), .config_in(config_in),
        .data_wr(data_wr), .data_rd(data_rd), .config_wr(config_wr),
        .data_out(data_out), .config_out(config_out)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clr_in();
        r0_req = 1'b0; r0_data_wr = 1'b0; r0_data_rd = 1'b0; r0_config_wr = 1'b0;
        r1_req = 1'b0; r1_data_wr = 1'b0; r1_data_rd = 1'b0; r1_config_wr = 1'b0;
        r0_data_in = '0; r0_config_in = '0; r1_data_in = '0; r1_config_in = '0;
        data_out = '0; config_out = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr_in();
        repeat (3) @(negedge clk);
        #1;
        chk1("rst_r0_gnt", r0_gnt, 1'b0);
        chk1("rst_r1_gnt", r1_gnt, 1'b0);
        chk1("rst_r0_timeout", r0_timeout, 1'b0);
        chk1("rst_r1_timeout", r1_timeout, 1'b0);
        rst_n = 1'b1;
    endtask

    // Directed vector table
    typedef struct {
        bit          r0q, r1q, r0dwr, r1cwr;
        bit          g0, g1, dwr, cwr;
        logic [31:0] din, r1cout;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(bit a, bit b, bit c, bit d, bit g0, bit g1,
                                bit dw, bit cw, logic [31:0] din, logic [31:0] co);
        vec_t v;
        v.r0q = a; v.r1q = b; v.r0dwr = c; v.r1cwr = d;
        v.g0 = g0; v.g1 = g1; v.dwr = dw; v.cwr = cw;
        v.din = din; v.r1cout = co;
        return v;
    endfunction

    // Ownership-level reference model
    int m_owner;
    bit m_gap;
    int m_idle;
    bit m_blk[2];
    int m_last;
    bit m_to[2];

    task automatic model_reset();
        m_owner = -1; m_gap = 1'b0; m_idle = 0;
        m_blk[0] = 1'b0; m_blk[1] = 1'b0;
        m_last = 1;
        m_to[0] = 1'b0; m_to[1] = 1'b0;
    endtask

    task automatic model_check(input int cyc);
        bit g0, g1;
        g0 = (m_owner == 0);
        g1 = (m_owner == 1);
        chk1($sformatf("rnd%0d_r0_gnt", cyc), r0_gnt, g0);
        chk1($sformatf("rnd%0d_r1_gnt", cyc), r1_gnt, g1);
        chk1($sformatf("rnd%0d_r0_timeout", cyc), r0_timeout, m_to[0]);
        chk1($sformatf("rnd%0d_r1_timeout", cyc), r1_timeout, m_to[1]);
        chk1($sformatf("rnd%0d_data_wr", cyc), data_wr, (g0 && r0_data_wr) || (g1 && r1_data_wr));
        chk1($sformatf("rnd%0d_data_rd", cyc), data_rd, (g0 && r0_data_rd) || (g1 && r1_data_rd));
        chk1($sformatf("rnd%0d_config_wr", cyc), config_wr, (g0 && r0_config_wr) || (g1 && r1_config_wr));
        chk32($sformatf("rnd%0d_data_in", cyc), data_in, g0 ? r0_data_in : (g1 ? r1_data_in : 32'd0));
        chk32($sformatf("rnd%0d_config_in", cyc), config_in, g0 ? r0_config_in : (g1 ? r1_config_in : 32'd0));
        chk32($sformatf("rnd%0d_r0_data_out", cyc), r0_data_out, g0 ? data_out : 32'd0);
        chk32($sformatf("rnd%0d_r0_config_out", cyc), r0_config_out, g0 ? config_out : 32'd0);
        chk32($sformatf("rnd%0d_r1_data_out", cyc), r1_data_out, g1 ? data_out : 32'd0);
        chk32($sformatf("rnd%0d_r1_config_out", cyc), r1_config_out, g1 ? config_out : 32'd0);
    endtask

    task automatic model_step();
        bit req[2];
        bit nb[2];
        bit nto[2];
        bit stb, e0, e1;
        int n;
        if (!rst_n) begin
            model_reset();
            return;
        end
        req[0] = r0_req; req[1] = r1_req;
        nto[0] = 1'b0; nto[1] = 1'b0;
        nb[0] = m_blk[0] && req[0];
        nb[1] = m_blk[1] && req[1];
        if (m_owner >= 0) begin
            stb = (m_owner == 0) ? (r0_data_wr || r0_data_rd || r0_config_wr)
                                 : (r1_data_wr || r1_data_rd || r1_config_wr);
            if (!req[m_owner]) begin
                m_owner = -1;
                m_gap = 1'b1;
            end else if (!stb && (m_idle + 1 == TO)) begin
                nto[m_owner] = 1'b1;
                nb[m_owner] = 1'b1;
                m_owner = -1;
                m_gap = 1'b1;
            end else begin
                m_idle = stb ? 0 : m_idle + 1;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else begin
            e0 = req[0] && !m_blk[0];
            e1 = req[1] && !m_blk[1];
            n = -1;
            if (e0 && e1) n = (m_last == 1) ? 0 : 1;
            else if (e0)  n = 0;
            else if (e1)  n = 1;
            if (n >= 0) begin
                m_owner = n;
                m_last = n;
                m_idle = 0;
            end
        end
        m_blk = nb;
        m_to = nto;
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL global_time_limit: got expired expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int n_to;
        bit eg0, eg1;

        // Two-owner handover, strobe gating, and alternating ties.
        tbl[0]  = mk(H,H,L,L, L,L,L,L, 32'd0, 32'd0);
        tbl[1]  = mk(H,H,H,H, H,L,H,L, D0, 32'd0);
        tbl[2]  = mk(H,H,L,H, H,L,L,L, D0, 32'd0);
        tbl[3]  = mk(H,H,L,L, H,L,L,L, D0, 32'd0);
        tbl[4]  = mk(H,H,L,L, H,L,L,L, D0, 32'd0);
        tbl[5]  = mk(L,H,L,L, H,L,L,L, D0, 32'd0);
        tbl[6]  = mk(L,H,L,H, L,L,L,L, 32'd0, 32'd0);
        tbl[7]  = mk(L,H,L,L, L,L,L,L, 32'd0, 32'd0);
        tbl[8]  = mk(H,H,H,H, L,H,L,H, D1, PCO);
        tbl[9]  = mk(H,H,L,L, L,H,L,L, D1, PCO);
        tbl[10] = mk(H,H,L,L, L,H,L,L, D1, PCO);
        tbl[11] = mk(H,L,L,L, L,H,L,L, D1, PCO);
        tbl[12] = mk(H,H,L,L, L,L,L,L, 32'd0, 32'd0);
        tbl[13] = mk(H,H,L,L, L,L,L,L, 32'd0, 32'd0);
        tbl[14] = mk(H,H,L,L, H,L,L,L, D0, 32'd0);
        tbl[15] = mk(H,H,L,L, H,L,L,L, D0, 32'd0);
        tbl[16] = mk(H,H,L,L, H,L,L,L, D0, 32'd0);
        tbl[17] = mk(L,H,L,L, H,L,L,L, D0, 32'd0);
        tbl[18] = mk(H,H,L,L, L,L,L,L, 32'd0, 32'd0);
        tbl[19] = mk(H,H,L,L, L,L,L,L, 32'd0, 32'd0);
        tbl[20] = mk(H,H,L,L, L,H,L,L, D1, PCO);
        tbl[21] = mk(H,H,L,L, L,H,L,L, D1, PCO);

        do_reset();
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            r0_req = tbl[i].r0q; r1_req = tbl[i].r1q;
            r0_data_wr = tbl[i].r0dwr; r1_config_wr = tbl[i].r1cwr;
            r0_data_in = D0; r1_data_in = D1; r0_config_in = C0; r1_config_in = C1;
            data_out = PDO; config_out = PCO;
            #1;
            chk1($sformatf("vec%0d_r0_gnt", i), r0_gnt, tbl[i].g0);
            chk1($sformatf("vec%0d_r1_gnt", i), r1_gnt, tbl[i].g1);
            chk1($sformatf("vec%0d_data_wr", i), data_wr, tbl[i].dwr);
            chk1($sformatf("vec%0d_config_wr", i), config_wr, tbl[i].cwr);
            chk32($sformatf("vec%0d_data_in", i), data_in, tbl[i].din);
            chk32($sformatf("vec%0d_r1_config_out", i), r1_config_out, tbl[i].r1cout);
            chk1($sformatf("vec%0d_timeouts", i), r0_timeout | r1_timeout, 1'b0);
        end

        // Watchdog revoke of an idle owner, then block until req drops once.
        do_reset();
        n_to = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            r1_req = (c != 20);
            #1;
            eg1 = (c >= 1 && c <= 8) || (c >= 22);
            chk1($sformatf("wd1_c%0d_r1_gnt", c), r1_gnt, eg1);
            chk1($sformatf("wd1_c%0d_r1_timeout", c), r1_timeout, c == 9);
            chk1($sformatf("wd1_c%0d_r0_gnt", c), r0_gnt, 1'b0);
            if (r1_timeout === 1'b1) n_to++;
        end
        chk32("wd1_pulse_count", 32'(n_to), 32'd1);

        // Strobe on the cycle the watchdog would fire keeps the grant.
        do_reset();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            r0_req = 1'b1;
            r0_data_rd = (c == 8);
            data_out = $urandom;
            #1;
            eg0 = (c >= 1 && c <= 16);
            chk1($sformatf("wd0_c%0d_r0_gnt", c), r0_gnt, eg0);
            chk1($sformatf("wd0_c%0d_r0_timeout", c), r0_timeout, c == 17);
            chk32($sformatf("wd0_c%0d_r0_data_out", c), r0_data_out, eg0 ? data_out : 32'd0);
            if (c == 8) chk1("wd0_data_rd", data_rd, 1'b1);
        end

        // Synchronous reset in the middle of an OWN1 transaction.
        do_reset();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            r1_req = 1'b1;
            rst_n = (c != 3);
            r1_data_wr = 1'b1;
            r1_data_in = D1;
            data_out = PDO;
            #1;
            eg1 = (c >= 1 && c <= 3) || (c >= 5);
            chk1($sformatf("mrst_c%0d_r1_gnt", c), r1_gnt, eg1);
            chk1($sformatf("mrst_c%0d_data_wr", c), data_wr, eg1);
            chk32($sformatf("mrst_c%0d_data_in", c), data_in, eg1 ? D1 : 32'd0);
            chk32($sformatf("mrst_c%0d_r1_data_out", c), r1_data_out, eg1 ? PDO : 32'd0);
        end
        rst_n = 1'b1;

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(9) == 0) r0_req = ~r0_req;
            if ($urandom_range(9) == 0) r1_req = ~r1_req;
            r0_data_wr   = ($urandom_range(15) == 0);
            r0_data_rd   = ($urandom_range(15) == 0);
            r0_config_wr = ($urandom_range(15) == 0);
            r1_data_wr   = ($urandom_range(15) == 0);
            r1_data_rd   = ($urandom_range(15) == 0);
            r1_config_wr = ($urandom_range(15) == 0);
            r0_data_in = $urandom; r0_config_in = $urandom;
            r1_data_in = $urandom; r1_config_in = $urandom;
            data_out = $urandom; config_out = $urandom;
            rst_n = ($urandom_range(249) != 0);
            #1;
            model_check(c);
            model_step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
